// File: rtl/line_refill_master.sv
// I-cache line refill over AHB-Lite: one wrapping burst, critical word forwarded first, then the assembled line.
// Zero-wait crit_valid 3 cycles / line_valid BEATS+2 cycles after accept; single miss in flight, hready=0 stalls hold the bus.
module line_refill_master #(
  parameter int CACHE_LINE = 128
) (
  input  logic                  hclk,
  input  logic                  hrstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  crit_valid,
  output logic [31:0]           crit_data,
  output logic                  line_valid,
  output logic [CACHE_LINE-1:0] line_data,
  output logic [31:0]           line_addr,
  output logic                  line_err,
  output logic [31:0]           haddr,
  output logic [1:0]            htrans,
  output logic [2:0]            hburst,
  output logic [2:0]            hsize,
  output logic                  hwrite,
  output logic [3:0]            hprot,
  output logic [31:0]           hwdata,
  input  logic [31:0]           hrdata,
  input  logic                  hready,
  input  logic                  hresp
);
  localparam int BEATS = CACHE_LINE / 32;
  localparam int BW    = $clog2(BEATS);
  localparam int OFFW  = $clog2(CACHE_LINE / 8);
  localparam logic [31:0]   BASE_MASK = ~((32'd1 << OFFW) - 32'd1);
  localparam logic [BW-1:0] ONE       = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] LAST_BEAT = {BW{1'b1}};
  localparam logic [2:0]    BURST     = (BEATS == 4) ? 3'b010 : (BEATS == 8) ? 3'b100 : 3'b110;
  localparam logic [1:0]    T_IDLE    = 2'b00;
  localparam logic [1:0]    T_NONSEQ  = 2'b10;
  localparam logic [1:0]    T_SEQ     = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LAST, S_DONE, S_ERR} state_t;

  state_t                state_q;
  logic [31:0]           base_q;
  logic [31:0]           haddr_q;
  logic [31:0]           crit_data_q;
  logic [BW-1:0]         start_q;
  logic [BW-1:0]         acnt_q;
  logic [BW-1:0]         dcnt_q;
  logic                  dph_q;
  logic                  req_ready_q;
  logic                  crit_valid_q;
  logic                  line_valid_q;
  logic                  line_err_q;
  logic [1:0]            htrans_q;
  logic [2:0]            hburst_q;
  logic [CACHE_LINE-1:0] line_data_q;

  logic [BW-1:0]         nbeat_d;
  logic [BW-1:0]         slot_d;
  logic [BW+4:0]         slot_lo_d;
  logic [31:0]           haddr_d;
  logic                  err_first;
  logic                  capture;

  assign nbeat_d   = start_q + acnt_q + ONE;
  assign haddr_d   = base_q | {{(30-BW){1'b0}}, nbeat_d, 2'b00};
  assign slot_d    = start_q + dcnt_q;
  assign slot_lo_d = {slot_d, 5'd0};
  assign err_first = dph_q && hresp && !hready;
  assign capture   = dph_q && hready && !hresp && (state_q == S_ADDR || state_q == S_LAST);

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      haddr_q      <= '0;
      crit_data_q  <= '0;
      start_q      <= '0;
      acnt_q       <= '0;
      dcnt_q       <= '0;
      dph_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      crit_valid_q <= 1'b0;
      line_valid_q <= 1'b0;
      line_err_q   <= 1'b0;
      htrans_q     <= T_IDLE;
      hburst_q     <= '0;
      line_data_q  <= '0;
    end else begin
      crit_valid_q <= 1'b0;
      line_valid_q <= 1'b0;
      line_err_q   <= 1'b0;
      if (capture) begin
        line_data_q[slot_lo_d +: 32] <= hrdata;
        dcnt_q                       <= dcnt_q + ONE;
        if (dcnt_q == '0) begin
          crit_valid_q <= 1'b1;
          crit_data_q  <= hrdata;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            base_q      <= req_addr & BASE_MASK;
            start_q     <= req_addr[OFFW-1:2];
            haddr_q     <= {req_addr[31:2], 2'b00};
            htrans_q    <= T_NONSEQ;
            hburst_q    <= BURST;
            acnt_q      <= '0;
            dcnt_q      <= '0;
            dph_q       <= 1'b0;
            req_ready_q <= 1'b0;
            state_q     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (err_first) begin
            htrans_q <= T_IDLE;
            state_q  <= S_ERR;
          end else if (hready) begin
            dph_q <= 1'b1;
            if (acnt_q == LAST_BEAT) begin
              htrans_q <= T_IDLE;
              state_q  <= S_LAST;
            end else begin
              acnt_q   <= acnt_q + ONE;
              haddr_q  <= haddr_d;
              htrans_q <= T_SEQ;
            end
          end
        end
        S_LAST: begin
          if (err_first) begin
            state_q <= S_ERR;
          end else if (hready) begin
            dph_q        <= 1'b0;
            line_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_ERR: begin
          // second error cycle completes the response; nothing is captured
          if (hready) begin
            dph_q        <= 1'b0;
            line_valid_q <= 1'b1;
            line_err_q   <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // the first error cycle drops the pending beat to IDLE before the register catches up
  assign htrans     = err_first ? T_IDLE : htrans_q;
  assign haddr      = haddr_q;
  assign hburst     = hburst_q;
  assign hsize      = 3'b010;
  assign hwrite     = 1'b0;
  assign hprot      = 4'b0010;
  assign hwdata     = 32'h0;
  assign req_ready  = req_ready_q;
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
  assign line_valid = line_valid_q;
  assign line_err   = line_err_q;
  assign line_data  = line_data_q;
  assign line_addr  = base_q;
endmodule

// File: tb/tb_line_refill_master.sv
// Directed bench: 128-bit and 256-bit refill engines sharing one scripted AHB slave.
module tb_line_refill_master;
  logic hclk = 1'b0;
  logic hrstn;
  always #5 hclk = ~hclk;

  logic [31:0] req_addr, hrdata;
  logic        hready, hresp, req_valid0, req_valid1;

  logic         req_ready0, crit_valid0, line_valid0, line_err0, hwrite0;
  logic [31:0]  crit_data0, line_addr0, haddr0, hwdata0;
  logic [127:0] line_data0;
  logic [1:0]   htrans0;
  logic [2:0]   hburst0, hsize0;
  logic [3:0]   hprot0;

  logic         req_ready1, crit_valid1, line_valid1, line_err1, hwrite1;
  logic [31:0]  crit_data1, line_addr1, haddr1, hwdata1;
  logic [255:0] line_data1;
  logic [1:0]   htrans1;
  logic [2:0]   hburst1, hsize1;
  logic [3:0]   hprot1;

  line_refill_master #(.CACHE_LINE(128)) dut0 (
    .hclk(hclk), .hrstn(hrstn), .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr),
    .crit_valid(crit_valid0), .crit_data(crit_data0), .line_valid(line_valid0), .line_data(line_data0),
    .line_addr(line_addr0), .line_err(line_err0), .haddr(haddr0), .htrans(htrans0), .hburst(hburst0),
    .hsize(hsize0), .hwrite(hwrite0), .hprot(hprot0), .hwdata(hwdata0), .hrdata(hrdata),
    .hready(hready), .hresp(hresp));

  line_refill_master #(.CACHE_LINE(256)) dut1 (
    .hclk(hclk), .hrstn(hrstn), .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr),
    .crit_valid(crit_valid1), .crit_data(crit_data1), .line_valid(line_valid1), .line_data(line_data1),
    .line_addr(line_addr1), .line_err(line_err1), .haddr(haddr1), .htrans(htrans1), .hburst(hburst1),
    .hsize(hsize1), .hwrite(hwrite1), .hprot(hprot1), .hwdata(hwdata1), .hrdata(hrdata),
    .hready(hready), .hresp(hresp));

  logic         sel;
  logic         m_req_ready, m_crit_valid, m_line_valid, m_line_err;
  logic [31:0]  m_crit_data, m_line_addr, m_haddr;
  logic [255:0] m_line_data;
  logic [1:0]   m_htrans;
  logic [2:0]   m_hburst;

  always_comb begin
    m_req_ready  = sel ? req_ready1  : req_ready0;
    m_crit_valid = sel ? crit_valid1 : crit_valid0;
    m_line_valid = sel ? line_valid1 : line_valid0;
    m_line_err   = sel ? line_err1   : line_err0;
    m_crit_data  = sel ? crit_data1  : crit_data0;
    m_line_addr  = sel ? line_addr1  : line_addr0;
    m_haddr      = sel ? haddr1      : haddr0;
    m_htrans     = sel ? htrans1     : htrans0;
    m_hburst     = sel ? hburst1     : hburst0;
    m_line_data  = sel ? line_data1  : {128'b0, line_data0};
  end

  int checks, errors;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // data beat j of a burst for address a reads back {a[15:0], j}
  function automatic logic [31:0] word(input logic [31:0] a, input int j);
    return {a[15:0], 16'(j)};
  endfunction

  task automatic refill(input bit s, input logic [31:0] addr, input int waits, input int err_beat,
                        input int exp_crit, input int exp_lat, input logic [255:0] exp_line,
                        input bit hold, input logic [31:0] next_addr);
    int beats, start, abeat, dbeat, wleft, estage, crit_n, lat, w;
    bit dph, acc, idle_exp;
    logic [31:0] base;
    beats  = s ? 8 : 4;
    base   = addr & ~(32'(beats * 4) - 32'd1);
    start  = addr[7:2] % beats;
    sel    = s;
    req_addr = addr;
    if (s) req_valid1 = 1'b1; else req_valid0 = 1'b1;
    w = 0;
    while (!m_req_ready && w < 30) begin
      @(negedge hclk);
      w++;
    end
    chk("req_ready_wait", m_req_ready, 1'b1);
    @(posedge hclk);
    #1;
    if (hold) req_addr = next_addr;
    else begin
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
    end
    abeat = 0; dbeat = 0; wleft = 0; estage = 0; crit_n = 0; lat = 0; dph = 1'b0;
    for (int cyc = 1; cyc <= 60 && lat == 0; cyc++) begin
      @(negedge hclk);
      hresp = 1'b0; hready = 1'b1; hrdata = 32'h0;
      if (dph) begin
        if (dbeat == err_beat) begin
          hresp  = 1'b1;
          hready = (estage != 0);
          estage++;
        end else if (wleft > 0) begin
          hready = 1'b0;
          wleft--;
        end else begin
          hrdata = word(addr, dbeat);
        end
      end
      #1;
      idle_exp = (abeat >= beats) || (estage > 0);
      if (idle_exp) chk("htrans_idle", m_htrans, 2'b00);
      else begin
        chk("htrans", m_htrans, (abeat == 0) ? 2'b10 : 2'b11);
        chk("haddr", m_haddr, base | 32'(((start + abeat) % beats) * 4));
        chk("hburst", m_hburst, s ? 3'b100 : 3'b010);
      end
      if (m_crit_valid) begin
        crit_n++;
        chk("crit_cyc", cyc, exp_crit);
        chk("crit_data", m_crit_data, word(addr, 0));
      end
      if (m_line_valid) begin
        lat = cyc;
        chk("line_lat", cyc, exp_lat);
        chk("line_err", m_line_err, err_beat >= 0);
        chk("line_addr", m_line_addr, base);
        chk("crit_count", crit_n, (err_beat == 0) ? 0 : 1);
        if (err_beat < 0) chk("line_data", m_line_data, exp_line);
        if (err_beat != 0) chk("crit_hold", m_crit_data, word(addr, 0));
      end else begin
        chk("req_ready_busy", m_req_ready, 1'b0);
      end
      if (hready) begin
        acc = !idle_exp;
        dph = acc;
        if (acc) begin
          dbeat = abeat;
          wleft = waits;
          abeat++;
        end
      end
    end
    if (lat == 0) chk("line_timeout", lat, exp_lat);
    @(negedge hclk);
    #1;
    chk("ready_after", m_req_ready, 1'b1);
    chk("line_pulse", m_line_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    checks = 0; errors = 0; sel = 1'b0;
    req_valid0 = 1'b0; req_valid1 = 1'b0; req_addr = 32'h0;
    hrdata = 32'h0; hready = 1'b1; hresp = 1'b0; hrstn = 1'b0;
    repeat (3) @(negedge hclk);
    chk("rst_req_ready", req_ready0, 1'b1);
    chk("rst_htrans", htrans0, 2'b00);
    chk("rst_haddr", haddr0, 32'h0);
    chk("rst_hburst", hburst0, 3'b000);
    chk("rst_crit_valid", crit_valid0, 1'b0);
    chk("rst_crit_data", crit_data0, 32'h0);
    chk("rst_line_valid", line_valid0, 1'b0);
    chk("rst_line_err", line_err0, 1'b0);
    chk("rst_line_data", line_data0, 128'h0);
    chk("rst_line_addr", line_addr0, 32'h0);
    chk("hsize", hsize0, 3'b010);
    chk("hwrite", hwrite0, 1'b0);
    chk("hprot", hprot0, 4'b0010);
    chk("hwdata", hwdata0, 32'h0);
    chk("rst_req_ready1", req_ready1, 1'b1);
    chk("rst_line_data1", line_data1, 256'h0);
    hrstn = 1'b1;
    @(negedge hclk);
    #1;

    refill(1'b0, 32'h0000_1008, 0, -1, 3, 6,
           256'h1008_0001_1008_0000_1008_0003_1008_0002, 1'b0, 32'h0);
    refill(1'b0, 32'h0000_2000, 2, -1, 5, 14,
           256'h2000_0003_2000_0002_2000_0001_2000_0000, 1'b0, 32'h0);
    refill(1'b0, 32'h0000_5000, 0, 2, 3, 6, 256'h0, 1'b0, 32'h0);
    refill(1'b0, 32'h0000_6000, 0, 0, 0, 4, 256'h0, 1'b0, 32'h0);

    // reset in the middle of a burst
    sel = 1'b0; req_addr = 32'h0000_7000; req_valid0 = 1'b1;
    @(posedge hclk);
    #1;
    req_valid0 = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge hclk);
    #2;
    hrstn = 1'b0;
    #1;
    chk("mid_rst_htrans", htrans0, 2'b00);
    chk("mid_rst_req_ready", req_ready0, 1'b1);
    chk("mid_rst_haddr", haddr0, 32'h0);
    chk("mid_rst_line_data", line_data0, 128'h0);
    chk("mid_rst_crit_data", crit_data0, 32'h0);
    @(negedge hclk);
    hrstn = 1'b1; hrdata = 32'h0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge hclk);
      if (line_valid0) seen = 1'b1;
    end
    chk("mid_rst_no_line", seen, 1'b0);
    #1;
    refill(1'b0, 32'h0000_7000, 0, -1, 3, 6,
           256'h7000_0003_7000_0002_7000_0001_7000_0000, 1'b0, 32'h0);

    refill(1'b0, 32'h0000_3004, 0, -1, 3, 6,
           256'h3004_0002_3004_0001_3004_0000_3004_0003, 1'b1, 32'h0000_300C);
    refill(1'b0, 32'h0000_300C, 0, -1, 3, 6,
           256'h300C_0000_300C_0003_300C_0002_300C_0001, 1'b0, 32'h0);

    refill(1'b1, 32'h0000_401C, 0, -1, 3, 10,
           256'h401C0000_401C0007_401C0006_401C0005_401C0004_401C0003_401C0002_401C0001, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
